// File: rtl/xilinx_clock_bringup_ctrl.sv
// Clock front-end bring-up sequencer: MMCM reset, lock wait, IDELAYCTRL reset,
// ready wait, stability qualification, then user reset release with bounded retries.
module xilinx_clock_bringup_ctrl #(
    parameter int MMCM_RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT      = 65535,
    parameter int IDELAY_RST_CYCLES = 12,
    parameter int RDY_TIMEOUT       = 4095,
    parameter int STABLE_CYCLES     = 64,
    parameter int MAX_RETRY         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mmcm_locked,
    input  logic       idelayctrl_ready,
    output logic       mmcm_rst,
    output logic       idelayctrl_rst,
    output logic       user_rst,
    output logic       done,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int P_MAX = max2(max2(max2(MMCM_RST_CYCLES, LOCK_TIMEOUT),
                                     max2(IDELAY_RST_CYCLES, RDY_TIMEOUT)),
                                max2(STABLE_CYCLES, MAX_RETRY));
    localparam int CW = $clog2(P_MAX) + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MMCM_RST  = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_IDLY_RST  = 3'd3;
    localparam logic [2:0] S_WAIT_RDY  = 3'd4;
    localparam logic [2:0] S_STABLE    = 3'd5;
    localparam logic [2:0] S_RUN       = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    logic          r_lock_meta, r_lock_s;
    logic          r_rdy_meta, r_rdy_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retry;
    logic          r_mmcm_rst, r_idly_rst, r_user_rst, r_done, r_fail;

    logic [2:0]    w_next_state;
    logic [3:0]    w_next_retry;
    logic          w_fail_path;
    logic          w_mmcm_rst_next, w_idly_rst_next, w_user_rst_next;
    logic          w_done_next, w_fail_next;

    // Two-flop synchronizers for the asynchronous status inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_rdy_meta  <= 1'b0;
            r_rdy_s     <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_lock_s    <= r_lock_meta;
            r_rdy_meta  <= idelayctrl_ready;
            r_rdy_s     <= r_rdy_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_mmcm_rst <= 1'b1;
            r_idly_rst <= 1'b1;
            r_user_rst <= 1'b1;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= (w_next_state != r_state) ? '0 : r_cnt + CW'(1);
            r_retry    <= w_next_retry;
            r_mmcm_rst <= w_mmcm_rst_next;
            r_idly_rst <= w_idly_rst_next;
            r_user_rst <= w_user_rst_next;
            r_done     <= w_done_next;
            r_fail     <= w_fail_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_fail_path  = 1'b0;
        case (r_state)
            S_IDLE:      w_next_state = S_MMCM_RST;
            S_MMCM_RST:  if (r_cnt == CW'(MMCM_RST_CYCLES - 1)) w_next_state = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_lock_s)                                w_next_state = S_IDLY_RST;
                else if (r_cnt == CW'(LOCK_TIMEOUT - 1))     w_fail_path  = 1'b1;
            end
            // Ready is expected low while IDELAYCTRL is held in reset; only lock matters.
            S_IDLY_RST: begin
                if (!r_lock_s)                                    w_fail_path  = 1'b1;
                else if (r_cnt == CW'(IDELAY_RST_CYCLES - 1))     w_next_state = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!r_lock_s)                               w_fail_path  = 1'b1;
                else if (r_rdy_s)                            w_next_state = S_STABLE;
                else if (r_cnt == CW'(RDY_TIMEOUT - 1))      w_fail_path  = 1'b1;
            end
            S_STABLE: begin
                if (!r_lock_s || !r_rdy_s)                   w_fail_path  = 1'b1;
                else if (r_cnt == CW'(STABLE_CYCLES - 1))    w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!r_lock_s)      w_next_state = S_MMCM_RST;
                else if (!r_rdy_s)  w_next_state = S_IDLY_RST;
            end
            S_FAIL:  w_next_state = S_FAIL;
            default: w_next_state = S_IDLE;
        endcase

        if (w_fail_path) begin
            if (r_retry == 4'(MAX_RETRY - 1)) begin
                w_next_state = S_FAIL;
            end else begin
                w_next_state = S_MMCM_RST;
                w_next_retry = r_retry + 4'd1;
            end
        end

        if (w_next_state == S_RUN) w_next_retry = '0;

        // Dropping enable overrides every other transition.
        if (!enable) begin
            w_next_state = S_IDLE;
            w_next_retry = '0;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_comb begin
        w_mmcm_rst_next = (w_next_state == S_IDLE) || (w_next_state == S_MMCM_RST) ||
                          (w_next_state == S_FAIL);
        w_idly_rst_next = (w_next_state == S_IDLE) || (w_next_state == S_MMCM_RST) ||
                          (w_next_state == S_WAIT_LOCK) || (w_next_state == S_IDLY_RST) ||
                          (w_next_state == S_FAIL);
        w_user_rst_next = (w_next_state != S_RUN);
        w_done_next     = (w_next_state == S_RUN);
        w_fail_next     = (w_next_state == S_FAIL);
    end

    assign mmcm_rst       = r_mmcm_rst;
    assign idelayctrl_rst = r_idly_rst;
    assign user_rst       = r_user_rst;
    assign done           = r_done;
    assign fail           = r_fail;
    assign retry_cnt      = r_retry;
    assign state          = r_state;

endmodule
